icache_responder: RTL and testbench
===================================

ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 SHALL have parameter NUM_LINES, default 64, number of direct-mapped lines (power of two, 4..256).
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, instruction word driven on icache_dout after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port icache_addr  input  32  fetch byte address from the fetch stage.
REQ-006 SHALL have port icache_re  input  1  fetch read enable.
REQ-007 SHALL have port icache_dout  output  32  instruction word returned to fetch.
REQ-008 SHALL have port stall  output  1  high while a miss is outstanding; icache_dout is invalid while high.
REQ-009 SHALL have port mem_req_valid  output  1  line refill request valid.
REQ-010 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-011 SHALL have port mem_req_addr  output  32  16-byte-aligned refill address.
REQ-012 SHALL have port mem_resp_valid  input  1  refill data valid, single-cycle pulse.
REQ-013 SHALL have port mem_resp_data  input  128  refill line; word k in bits [32k+31:32k].

Function
REQ-014 SHALL decode address as: bits[1:0] ignored, bits[3:2] word select, next log2(NUM_LINES) bits index, remaining upper bits tag.
REQ-015 SHALL store per line: valid bit, tag, 128-bit data.
REQ-016 SHALL implement FSM states IDLE, MISS_REQ, MISS_WAIT, FILL.
REQ-017 SHALL, in IDLE with icache_re=1 in cycle N, register the address and look up; hit → cycle N+1 icache_dout = selected word, stall=0.
REQ-018 SHALL, on lookup miss, assert stall in cycle N+1 and enter MISS_REQ; the latched address is used for the whole miss, icache_addr is ignored until stall drops.
REQ-019 SHALL, in MISS_REQ, hold mem_req_valid=1 with mem_req_addr = {latched_addr[31:4],4'b0} stable until cycle where mem_req_ready=1, then enter MISS_WAIT with mem_req_valid=0.
REQ-020 SHALL sample mem_resp_valid only in MISS_WAIT; on it write data, tag, valid=1 to the indexed line and enter FILL.
REQ-021 SHALL, in FILL (one cycle), drive icache_dout = requested word, stall=0, return to IDLE; total miss penalty = handshake wait + response wait + 2 cycles.
REQ-022 SHALL, with icache_re=0 in IDLE, hold icache_dout and not perform lookup or miss.
REQ-023 SHALL replace an existing valid line on conflict (tag mismatch) without writeback.
REQ-024 SHALL ignore mem_resp_valid outside MISS_WAIT and mem_req_ready outside MISS_REQ.
REQ-025 SHALL treat address 32'hFFFFFFFC like any other (no wrap special case); all tag bits compared.

Reset
REQ-026 SHALL, on reset, clear all valid bits, enter IDLE, drive stall=0, mem_req_valid=0, mem_req_addr=0, icache_dout=NOP_INST.
REQ-027 SHALL, on reset during MISS_REQ/MISS_WAIT/FILL, abandon the miss; a later mem_resp_valid SHALL NOT write the array.

Configuration
REQ-028 SHALL, with ICACHE_PERF_CNT_EN defined, add outputs hit_count[31:0] and miss_count[31:0], incrementing once per hit/miss lookup, wrapping at 2^32, cleared by reset.
REQ-029 SHALL, without ICACHE_PERF_CNT_EN, omit those ports and counters entirely; function otherwise identical.

Verification
REQ-030 SHALL test cold miss: reset, re=1 addr 0x00000104 → stall=1, mem_req_addr=0x00000100; respond word1=0x00500093 → next cycle dout=0x00500093, stall=0.
REQ-031 SHALL test hit after fill: addr 0x00000108 after REQ-030 line fill → dout = word2 one cycle later, stall stays 0, no mem_req_valid.
REQ-032 SHALL test conflict: fill 0x00000100 then access 0x00000500 (NUM_LINES=64, same index) → miss, refill; re-access 0x00000100 → miss again.
REQ-033 SHALL test backpressure: mem_req_ready low 5 cycles → mem_req_valid and mem_req_addr stable for all 5, stall high throughout.
REQ-034 SHALL test reset mid-miss: reset in MISS_WAIT, then mem_resp_valid pulse → no array write; next access same address misses; dout=0x00000013 after reset.
REQ-035 SHALL test with ICACHE_PERF_CNT_EN: sequence REQ-030/031 → hit_count=1, miss_count=1.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache front end with a single outstanding line refill.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_responder #(
    parameter int          NUM_LINES = 64,
    parameter logic [31:0] NOP_INST  = 32'h00000013
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  icache_addr,
    input  logic         icache_re,
    output logic [31:0]  icache_dout,
    output logic         stall,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  mem_req_addr,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MISS_REQ  = 2'd1;
    localparam logic [1:0] S_MISS_WAIT = 2'd2;
    localparam logic [1:0] S_FILL      = 2'd3;

    logic [1:0]           r_state;
    logic [31:2]          r_addr;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [127:0]         r_data [NUM_LINES];
    logic [31:0]          r_dout;
    logic                 r_stall;
    logic                 r_req_valid;
    logic [31:0]          r_req_addr;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [127:0]         w_line;
    logic                 w_hit;
    logic [31:0]          w_hit_word;
    logic [IDX_W-1:0]     w_fill_idx;
    logic [TAG_W-1:0]     w_fill_tag;
    logic [31:0]          w_fill_word;
    logic                 w_lookup;
    logic                 w_fill_write;
    logic                 w_unused;

    assign w_idx       = icache_addr[IDX_W+3:4];
    assign w_tag       = icache_addr[31:IDX_W+4];
    assign w_line      = r_data[w_idx];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit_word  = w_line[{icache_addr[3:2], 5'b00000} +: 32];

    // The refill always targets the address latched when the miss was detected.
    assign w_fill_idx  = r_addr[IDX_W+3:4];
    assign w_fill_tag  = r_addr[31:IDX_W+4];
    assign w_fill_word = mem_resp_data[{r_addr[3:2], 5'b00000} +: 32];

    assign w_lookup     = (r_state == S_IDLE) && icache_re;
    assign w_fill_write = (r_state == S_MISS_WAIT) && mem_resp_valid && !reset;
    assign w_unused     = ^icache_addr[1:0];

    assign icache_dout   = r_dout;
    assign stall         = r_stall;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_valid     <= '0;
            r_dout      <= NOP_INST;
            r_stall     <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (icache_re) begin
                        r_addr <= icache_addr[31:2];
                        if (w_hit) begin
                            r_dout <= w_hit_word;
                        end else begin
                            r_state     <= S_MISS_REQ;
                            r_stall     <= 1'b1;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= {icache_addr[31:4], 4'b0000};
                        end
                    end
                end
                S_MISS_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_MISS_WAIT;
                    end
                end
                S_MISS_WAIT: begin
                    if (mem_resp_valid) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_dout              <= w_fill_word;
                        r_stall             <= 1'b0;
                        r_state             <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage needs no reset; the valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (w_fill_write) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem_resp_data;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_lookup) begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end else begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end
`else
    logic w_lookup_unused;
    assign w_lookup_unused = w_lookup;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: stimulus pushes expected fetch words, a monitor pops them.
// Counter checks are compiled in when ICACHE_PERF_CNT_EN is defined.
module tb_icache_responder;

    logic         clk;
    logic         reset;
    logic [31:0]  icache_addr;
    logic         icache_re;
    logic [31:0]  icache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checkCount = 0;
    int passCount  = 0;
    logic [31:0] expQ [$];

    localparam logic [127:0] LINE_A = {32'h33333333, 32'h00A00113, 32'h00500093, 32'h11111111};
    localparam logic [127:0] LINE_B = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
    localparam logic [127:0] LINE_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    localparam logic [127:0] LINE_D = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};

    icache_responder #(.NUM_LINES(64), .NOP_INST(32'h00000013)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue a one-cycle fetch in IDLE; returns at the negedge of the following cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expWord);
        @(negedge clk);
        icache_addr = addr;
        icache_re   = 1'b1;
        expQ.push_back(expWord);
        @(negedge clk);
        icache_re   = 1'b0;
    endtask

    // Play the memory side of a refill, holding ready low for readyDelay cycles.
    task automatic memRespond(input logic [31:0] reqAddr, input logic [127:0] line, input int readyDelay);
        checkOutput("miss_stall", {31'b0, stall}, 32'd1);
        checkOutput("req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("req_addr", mem_req_addr, reqAddr);
        icache_addr = 32'hDEADBEEC;
        for (int i = 0; i < readyDelay; i++) begin
            @(negedge clk);
            checkOutput("bp_req_valid", {31'b0, mem_req_valid}, 32'd1);
            checkOutput("bp_req_addr", mem_req_addr, reqAddr);
            checkOutput("bp_stall", {31'b0, stall}, 32'd1);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checkOutput("wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("wait_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = line;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checkOutput("fill_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
    endtask

    // Monitor: after each accepted fetch, wait for stall to be low and compare against the scoreboard.
    initial begin : monitor
        int waitCycles;
        bit seen;
        forever begin
            @(posedge clk);
            if (icache_re && !reset && !stall) begin
                waitCycles = 0;
                seen = 1'b0;
                while (!seen && waitCycles < 100) begin
                    @(negedge clk);
                    if (!stall) seen = 1'b1;
                    else waitCycles++;
                end
                if (!seen) begin
                    checkCount++;
                    $display("[TB] FAIL response_timeout: stall still 1 after %0d cycles, expected 0", waitCycles);
                end else if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_response: got 0x%08h, expected no response", icache_dout);
                end else begin
                    checkOutput("dout", icache_dout, expQ.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        int drain;
        reset          = 1'b1;
        icache_addr    = 32'h0;
        icache_re      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        checkOutput("reset_dout", icache_dout, 32'h00000013);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("reset_req_addr", mem_req_addr, 32'h0);

        // Cold miss, then hits on the same line.
        applyStimulus(32'h00000104, 32'h00500093);
        memRespond(32'h00000100, LINE_A, 0);
        applyStimulus(32'h00000108, 32'h00A00113);
        checkOutput("hit_stall", {31'b0, stall}, 32'd0);
        checkOutput("hit_req_valid", {31'b0, mem_req_valid}, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        checkOutput("hit_count", hit_count, 32'd1);
        checkOutput("miss_count", miss_count, 32'd1);
`endif
        applyStimulus(32'h0000010C, 32'h33333333);

        // Conflict on index 0x10 evicts line A, which then misses again under backpressure.
        applyStimulus(32'h00000500, 32'hB0B0B0B0);
        memRespond(32'h00000500, LINE_B, 2);
        applyStimulus(32'h00000100, 32'h11111111);
        memRespond(32'h00000100, LINE_A, 5);

        // Idle with re low holds the last word.
        icache_addr = 32'h00000500;
        repeat (3) @(negedge clk);
        checkOutput("hold_dout", icache_dout, 32'h11111111);
        checkOutput("hold_req_valid", {31'b0, mem_req_valid}, 32'd0);

        // Reset while waiting for the refill; the monitor sees the NOP after reset.
        applyStimulus(32'h00002000, 32'h00000013);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_stall", {31'b0, stall}, 32'd0);
        checkOutput("midreset_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("midreset_req_addr", mem_req_addr, 32'h0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = LINE_C;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checkOutput("stray_resp_dout", icache_dout, 32'h00000013);
        applyStimulus(32'h00002000, 32'hC0C0C0C0);
        memRespond(32'h00002000, LINE_C, 0);
        applyStimulus(32'h00002004, 32'hC1C1C1C1);

        // Top of the address space behaves like any other line.
        applyStimulus(32'hFFFFFFFC, 32'hD3D3D3D3);
        memRespond(32'hFFFFFFF0, LINE_D, 1);
        applyStimulus(32'hFFFFFFF8, 32'hD2D2D2D2);
        checkOutput("top_hit_req_valid", {31'b0, mem_req_valid}, 32'd0);

        drain = 0;
        while (expQ.size() != 0 && drain < 50) begin
            @(negedge clk);
            drain++;
        end
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
